id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register sitting directly downstream of the 64-entry integer/FP register file.
- Captures the two combinational read operands together with the destination and control bundle of the instruction in decode.
- Applies a same-cycle writeback bypass, because the register file writes on the clock edge while reads are combinational.
- Tracks pending writes from multi-cycle FP ops in a scoreboard, stalls decode on RAW/WAW hazards, and supports stall/flush handshakes toward EX.

Parameters:
- N, 32, datapath width; matches the register file word width.
- address_size, 6, register address width (64 registers: 0-31 integer, 32-63 FP).
- CTRL_W, 16, width of the opaque decode control bundle.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode holds a valid instruction.
- id_rs_addr  in  address_size  source 1 address (also drives register file rs_address).
- id_rt_addr  in  address_size  source 2 address (also drives register file rt_address).
- id_rd_addr  in  address_size  destination address.
- id_rs_data  in  N  register file read_data_1.
- id_rt_data  in  N  register file read_data_2.
- id_reg_write  in  1  instruction writes id_rd_addr.
- id_long_op  in  1  destination is produced by a multi-cycle FP unit.
- id_ctrl  in  CTRL_W  decode control bundle, passed through.
- ex_ready  in  1  EX accepts the current ex_* contents this cycle.
- flush  in  1  kill the instruction in decode and the one held in ID/EX.
- wb_write  in  1  writeback strobe (same signal as register file write).
- wb_addr  in  address_size  writeback address.
- wb_data  in  N  writeback data.
- id_stall  out  1  decode must hold; combinational.
- ex_valid  out  1  ID/EX holds a valid instruction.
- ex_rs_data  out  N  registered operand 1.
- ex_rt_data  out  N  registered operand 2.
- ex_rd_addr  out  address_size  registered destination.
- ex_reg_write  out  1  registered write enable.
- ex_long_op  out  1  registered long-op flag.
- ex_ctrl  out  CTRL_W  registered control bundle.

Behaviour:
- Reset (reset=0, asynchronous): all ex_* outputs are 0, ex_valid=0, and the 64-bit pending vector is 0. Outputs are held at these values while reset stays low.
- Bypass operand 1: op1 = wb_data if wb_write && wb_addr==id_rs_addr, else id_rs_data. Operand 2 uses the same rule with id_rt_addr. Address 0 gets no special case, consistent with the register file.
- Hazard, combinational: id_valid && (src_busy(rs) || src_busy(rt) || (id_reg_write && src_busy(rd))).
- src_busy(a) = pending[a] && !(wb_write && wb_addr==a). A same-cycle writeback resolves the hazard through the bypass.
- Accept: accept = id_valid && !hazard && (!ex_valid || ex_ready) && !flush.
- id_stall = id_valid && !accept && !flush. Flush overrides stall.
- ID/EX register update, in priority order:
  1. flush: ex_valid<=0.
  2. accept: load every ex_* field from the bypassed operands and the id_* fields; ex_valid<=1.
  3. ex_ready: ex_valid<=0 (bubble), data fields hold.
  4. otherwise: hold all fields.
- Latency: one cycle from accept to ex_valid.
- Scoreboard set: on accept && id_reg_write && id_long_op, set pending[id_rd_addr].
- Scoreboard clear: on wb_write, clear pending[wb_addr].
- Simultaneous set and clear on the same address: set wins, because the new producer is outstanding.
- Flush does not clear the scoreboard; in-flight long ops still write back. A flushed decode instruction never sets a bit.
- Back-pressure: while ex_valid && !ex_ready, the ex_* outputs are stable and id_stall=1 for any valid decode.
- Reset mid-operation: the pending vector is lost. The pipeline controller must drain or reset the FP units on the same reset.

Decomposition:
- Shared package (cpu_pkg) holds:
  - CTRL_W and the control-bundle field offsets (alu_op, mem_rd, mem_wr, fp_sel, branch);
  - REG_COUNT=64;
  - FP_BASE=32.
- One sub-module, hazard_scoreboard, contains the 64-bit pending vector, its set/clear logic and the hazard computation. The pipeline register and bypass stay in the top module.

Test Plan:
- Plain issue: id_valid=1, rs=3 (data 0x11), rt=4 (0x22), ex_ready=1 → next cycle ex_valid=1, ex_rs_data=0x11, ex_rt_data=0x22, id_stall=0.
- Bypass: wb_write=1, wb_addr=3, wb_data=0xABCD with id_rs_addr=3 and id_rs_data=0x11 → ex_rs_data=0xABCD.
- RAW on long op: issue long op with rd=40, then an instruction reading rs=40 → id_stall=1 until wb_write to 40. In that cycle the instruction is accepted with the bypassed data, and pending[40] becomes 0.
- Back-pressure: ex_valid=1, ex_ready=0 for 3 cycles → ex_* unchanged and id_stall=1; when ex_ready=1 the next instruction loads.
- Flush: flush=1 while ex_valid=1 and id_valid=1 with a long op to rd=33 → ex_valid=0, pending[33] stays 0, id_stall=0.
- Async reset: drop reset mid-stall with pending[40]=1 → ex_valid=0 and all outputs 0 immediately; pending vector is 0 after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, register-file layout and decode control-bundle layout
package cpu_pkg;

  // Datapath and register-file geometry
  localparam int N_W       = 32;
  localparam int ADDR_W    = 6;
  localparam int REG_COUNT = 64;
  localparam int FP_BASE   = 32;

  // Decode control bundle: opaque to the ID/EX stage, consumed by EX
  localparam int CTRL_W      = 16;
  localparam int ALU_OP_LSB  = 0;
  localparam int ALU_OP_W    = 4;
  localparam int MEM_RD_BIT  = 4;
  localparam int MEM_WR_BIT  = 5;
  localparam int FP_SEL_LSB  = 6;
  localparam int FP_SEL_W    = 2;
  localparam int BRANCH_BIT  = 8;

  typedef struct packed {
    logic [6:0] rsvd;
    logic       branch;
    logic [1:0] fp_sel;
    logic       mem_wr;
    logic       mem_rd;
    logic [3:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - pending-write scoreboard for long FP ops and decode hazard detection
module hazard_scoreboard
  import cpu_pkg::*;
#(
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  input  logic [AW-1:0] rd_addr,
  input  logic          reg_write,
  input  logic          set_en,
  input  logic          wb_write,
  input  logic [AW-1:0] wb_addr,
  output logic          hazard
);

  localparam int RC = 1 << AW;

  logic [RC-1:0] pending_q;
  logic [RC-1:0] pending_d;
  logic          rs_busy;
  logic          rt_busy;
  logic          rd_busy;

  // A source is busy only if its producer is outstanding and not writing back right now
  always_comb begin
    rs_busy = pending_q[rs_addr] && !(wb_write && (wb_addr == rs_addr));
    rt_busy = pending_q[rt_addr] && !(wb_write && (wb_addr == rt_addr));
    rd_busy = pending_q[rd_addr] && !(wb_write && (wb_addr == rd_addr));
    hazard  = id_valid && (rs_busy || rt_busy || (reg_write && rd_busy));
  end

  // Clear on writeback first, then set, so a new producer to the same register stays outstanding
  always_comb begin
    pending_d = pending_q;
    if (wb_write) begin
      pending_d[wb_addr] = 1'b0;
    end
    if (set_en) begin
      pending_d[rd_addr] = 1'b1;
    end
  end

  // Pending vector state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with writeback bypass and long-op hazard stall
module id_ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int N            = N_W,
  parameter int address_size = ADDR_W,
  parameter int CTRL_W       = cpu_pkg::CTRL_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    id_valid,
  input  logic [address_size-1:0] id_rs_addr,
  input  logic [address_size-1:0] id_rt_addr,
  input  logic [address_size-1:0] id_rd_addr,
  input  logic [N-1:0]            id_rs_data,
  input  logic [N-1:0]            id_rt_data,
  input  logic                    id_reg_write,
  input  logic                    id_long_op,
  input  logic [CTRL_W-1:0]       id_ctrl,
  input  logic                    ex_ready,
  input  logic                    flush,
  input  logic                    wb_write,
  input  logic [address_size-1:0] wb_addr,
  input  logic [N-1:0]            wb_data,
  output logic                    id_stall,
  output logic                    ex_valid,
  output logic [N-1:0]            ex_rs_data,
  output logic [N-1:0]            ex_rt_data,
  output logic [address_size-1:0] ex_rd_addr,
  output logic                    ex_reg_write,
  output logic                    ex_long_op,
  output logic [CTRL_W-1:0]       ex_ctrl
);

  logic                    hazard;
  logic                    accept;
  logic [N-1:0]            op1;
  logic [N-1:0]            op2;

  logic                    ex_valid_q;
  logic [N-1:0]            ex_rs_data_q;
  logic [N-1:0]            ex_rt_data_q;
  logic [address_size-1:0] ex_rd_addr_q;
  logic                    ex_reg_write_q;
  logic                    ex_long_op_q;
  logic [CTRL_W-1:0]       ex_ctrl_q;

  // The register file writes on the edge, so a same-cycle writeback must be forwarded here
  always_comb begin
    op1      = (wb_write && (wb_addr == id_rs_addr)) ? wb_data : id_rs_data;
    op2      = (wb_write && (wb_addr == id_rt_addr)) ? wb_data : id_rt_data;
    accept   = id_valid && !hazard && (!ex_valid_q || ex_ready) && !flush;
    id_stall = id_valid && !accept && !flush;
  end

  hazard_scoreboard #(
    .AW (address_size)
  ) u_sb (
    .clk       (clk),
    .rst_n     (reset),
    .id_valid  (id_valid),
    .rs_addr   (id_rs_addr),
    .rt_addr   (id_rt_addr),
    .rd_addr   (id_rd_addr),
    .reg_write (id_reg_write),
    .set_en    (accept && id_reg_write && id_long_op),
    .wb_write  (wb_write),
    .wb_addr   (wb_addr),
    .hazard    (hazard)
  );

  // ID/EX register: flush kills, accept loads, a consumed slot becomes a bubble, else hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q     <= 1'b0;
      ex_rs_data_q   <= '0;
      ex_rt_data_q   <= '0;
      ex_rd_addr_q   <= '0;
      ex_reg_write_q <= 1'b0;
      ex_long_op_q   <= 1'b0;
      ex_ctrl_q      <= '0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (accept) begin
      ex_valid_q     <= 1'b1;
      ex_rs_data_q   <= op1;
      ex_rt_data_q   <= op2;
      ex_rd_addr_q   <= id_rd_addr;
      ex_reg_write_q <= id_reg_write;
      ex_long_op_q   <= id_long_op;
      ex_ctrl_q      <= id_ctrl;
    end else if (ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_rs_data   = ex_rs_data_q;
  assign ex_rt_data   = ex_rt_data_q;
  assign ex_rd_addr   = ex_rd_addr_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_long_op   = ex_long_op_q;
  assign ex_ctrl      = ex_ctrl_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [5:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0] id_rs_data, id_rt_data;
  logic        id_reg_write, id_long_op;
  logic [15:0] id_ctrl;
  logic        ex_ready, flush;
  logic        wb_write;
  logic [5:0]  wb_addr;
  logic [31:0] wb_data;
  logic        id_stall, ex_valid;
  logic [31:0] ex_rs_data, ex_rt_data;
  logic [5:0]  ex_rd_addr;
  logic        ex_reg_write, ex_long_op;
  logic [15:0] ex_ctrl;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [5:0]  rd;
    logic        rw;
    logic        lo;
    logic [15:0] ctrl;
  } exp_t;

  typedef struct {
    logic [5:0]  rs, rt, rd;
    logic [31:0] rs_d, rt_d;
    logic [15:0] ctrl;
    logic        wb_w;
    logic [5:0]  wb_a;
    logic [31:0] wb_d;
    logic [31:0] exp_rs, exp_rt;
  } vec_t;

  exp_t sbq[$];
  exp_t last;
  vec_t vecs[7];

  id_ex_operand_stage dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs_addr   (id_rs_addr),
    .id_rt_addr   (id_rt_addr),
    .id_rd_addr   (id_rd_addr),
    .id_rs_data   (id_rs_data),
    .id_rt_data   (id_rt_data),
    .id_reg_write (id_reg_write),
    .id_long_op   (id_long_op),
    .id_ctrl      (id_ctrl),
    .ex_ready     (ex_ready),
    .flush        (flush),
    .wb_write     (wb_write),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .id_stall     (id_stall),
    .ex_valid     (ex_valid),
    .ex_rs_data   (ex_rs_data),
    .ex_rt_data   (ex_rt_data),
    .ex_rd_addr   (ex_rd_addr),
    .ex_reg_write (ex_reg_write),
    .ex_long_op   (ex_long_op),
    .ex_ctrl      (ex_ctrl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [5:0] rs, input logic [5:0] rt, input logic [5:0] rd,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic rw, input logic lo,
                        input logic [15:0] ctrl);
    id_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_reg_write = rw; id_long_op = lo; id_ctrl = ctrl;
  endtask

  task automatic set_wb(input logic w, input logic [5:0] a, input logic [31:0] d);
    wb_write = w; wb_addr = a; wb_data = d;
  endtask

  task automatic chk_fields(input string tag);
    chk({tag, ".ex_rs_data"},   ex_rs_data,   last.rs_data);
    chk({tag, ".ex_rt_data"},   ex_rt_data,   last.rt_data);
    chk({tag, ".ex_rd_addr"},   ex_rd_addr,   last.rd);
    chk({tag, ".ex_reg_write"}, ex_reg_write, last.rw);
    chk({tag, ".ex_long_op"},   ex_long_op,   last.lo);
    chk({tag, ".ex_ctrl"},      ex_ctrl,      last.ctrl);
  endtask

  // Called at a falling edge with inputs already driven; checks stall, clocks, checks ID/EX
  task automatic step(input string tag, input bit exp_acc, input bit exp_stall, input bit exp_valid,
                      input logic [31:0] ers, input logic [31:0] ert);
    exp_t e;
    #1;
    chk({tag, ".id_stall"}, id_stall, exp_stall);
    if (exp_acc) begin
      e = '{ers, ert, id_rd_addr, id_reg_write, id_long_op, id_ctrl};
      sbq.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".ex_valid"}, ex_valid, exp_valid);
    if (exp_acc) begin
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL %s.scoreboard_empty actual=0 required=1", tag);
      end else begin
        last = sbq.pop_front();
      end
    end
    chk_fields(tag);
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    //          rs  rt  rd  rs_d          rt_d          ctrl     wb_w  wb_a  wb_d          exp_rs        exp_rt
    vecs[0] = '{6'd3,  6'd4,  6'd8,  32'h11,       32'h22,       16'h0011, 1'b0, 6'd0,  32'h0,        32'h11,       32'h22};
    vecs[1] = '{6'd3,  6'd5,  6'd9,  32'h11,       32'h33,       16'h0022, 1'b1, 6'd3,  32'hABCD,     32'hABCD,     32'h33};
    vecs[2] = '{6'd7,  6'd7,  6'd7,  32'h1,        32'h1,        16'h0104, 1'b1, 6'd7,  32'h55,       32'h55,       32'h55};
    vecs[3] = '{6'd0,  6'd1,  6'd2,  32'h99,       32'h77,       16'h0030, 1'b1, 6'd0,  32'h1234,     32'h1234,     32'h77};
    vecs[4] = '{6'd9,  6'd10, 6'd11, 32'hDEAD,     32'hBEEF,     16'hFFFF, 1'b1, 6'd11, 32'h1,        32'hDEAD,     32'hBEEF};
    vecs[5] = '{6'd63, 6'd32, 6'd34, 32'hFFFFFFFF, 32'h0,        16'h0040, 1'b1, 6'd32, 32'hCAFE,     32'hFFFFFFFF, 32'hCAFE};
    vecs[6] = '{6'd12, 6'd13, 6'd14, 32'h12,       32'h13,       16'h8001, 1'b0, 6'd12, 32'hBAD,      32'h12,       32'h13};

    reset = 1'b0;
    flush = 1'b0;
    ex_ready = 1'b1;
    set_id(1'b0, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0);
    set_wb(1'b0, 6'd0, 32'h0);
    last = '{32'h0, 32'h0, 6'd0, 1'b0, 1'b0, 16'h0};
    repeat (2) @(negedge clk);
    chk("reset.ex_valid", ex_valid, 1'b0);
    chk_fields("reset");
    chk("reset.pending", dut.u_sb.pending_q, 64'h0);
    reset = 1'b1;

    // Plain issue and bypass vectors, EX always ready
    for (int i = 0; i < 7; i++) begin
      set_id(1'b1, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].rs_d, vecs[i].rt_d, 1'b1, 1'b0, vecs[i].ctrl);
      set_wb(vecs[i].wb_w, vecs[i].wb_a, vecs[i].wb_d);
      step($sformatf("vec%0d", i), 1'b1, 1'b0, 1'b1, vecs[i].exp_rs, vecs[i].exp_rt);
    end
    set_wb(1'b0, 6'd0, 32'h0);

    // RAW on a long op to r40, resolved by the writeback bypass
    set_id(1'b1, 6'd1, 6'd2, 6'd40, 32'h100, 32'h200, 1'b1, 1'b1, 16'h0041);
    step("raw_issue", 1'b1, 1'b0, 1'b1, 32'h100, 32'h200);
    chk("raw_pending_set", dut.u_sb.pending_q[40], 1'b1);
    set_id(1'b1, 6'd40, 6'd2, 6'd5, 32'h0, 32'h200, 1'b1, 1'b0, 16'h0002);
    step("raw_stall0", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    step("raw_stall1", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    set_wb(1'b1, 6'd40, 32'h4040);
    step("raw_wb", 1'b1, 1'b0, 1'b1, 32'h4040, 32'h200);
    chk("raw_pending_clear", dut.u_sb.pending_q[40], 1'b0);
    set_wb(1'b0, 6'd0, 32'h0);

    // WAW on r41, then set-wins when a new long op to r41 meets its writeback
    set_id(1'b1, 6'd1, 6'd2, 6'd41, 32'h1, 32'h2, 1'b1, 1'b1, 16'h0041);
    step("waw_issue", 1'b1, 1'b0, 1'b1, 32'h1, 32'h2);
    set_id(1'b1, 6'd3, 6'd4, 6'd41, 32'h3, 32'h4, 1'b1, 1'b0, 16'h0003);
    step("waw_stall", 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    set_id(1'b1, 6'd3, 6'd4, 6'd41, 32'h3, 32'h4, 1'b1, 1'b1, 16'h0043);
    set_wb(1'b1, 6'd41, 32'h4141);
    step("set_wins", 1'b1, 1'b0, 1'b1, 32'h3, 32'h4);
    chk("set_wins_pending", dut.u_sb.pending_q[41], 1'b1);
    set_id(1'b0, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0);
    step("wb41_idle", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wb41_pending", dut.u_sb.pending_q[41], 1'b0);
    set_wb(1'b0, 6'd0, 32'h0);

    // Back-pressure: EX holds for three cycles, then takes the waiting instruction
    set_id(1'b1, 6'd5, 6'd6, 6'd7, 32'hA5, 32'hB6, 1'b1, 1'b0, 16'h0105);
    step("bp_first", 1'b1, 1'b0, 1'b1, 32'hA5, 32'hB6);
    ex_ready = 1'b0;
    set_id(1'b1, 6'd8, 6'd9, 6'd10, 32'hC8, 32'hD9, 1'b1, 1'b0, 16'h0206);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("bp_hold%0d", i), 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
    end
    ex_ready = 1'b1;
    step("bp_release", 1'b1, 1'b0, 1'b1, 32'hC8, 32'hD9);

    // Flush kills the held instruction and the long op in decode without scoreboarding it
    ex_ready = 1'b0;
    flush = 1'b1;
    set_id(1'b1, 6'd11, 6'd12, 6'd33, 32'hE1, 32'hE2, 1'b1, 1'b1, 16'h0047);
    step("flush", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("flush_pending33", dut.u_sb.pending_q[33], 1'b0);
    flush = 1'b0;
    set_id(1'b1, 6'd33, 6'd12, 6'd14, 32'h33, 32'hE2, 1'b1, 1'b0, 16'h0008);
    step("after_flush", 1'b1, 1'b0, 1'b1, 32'h33, 32'hE2);
    ex_ready = 1'b1;

    // Asynchronous reset in the middle of a stall on r40
    set_id(1'b1, 6'd1, 6'd2, 6'd40, 32'h7, 32'h8, 1'b1, 1'b1, 16'h0041);
    step("rst_issue", 1'b1, 1'b0, 1'b1, 32'h7, 32'h8);
    set_id(1'b1, 6'd40, 6'd2, 6'd6, 32'h9, 32'h8, 1'b1, 1'b0, 16'h0009);
    #1;
    chk("rst_pre.id_stall", id_stall, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    sbq.delete();
    last = '{32'h0, 32'h0, 6'd0, 1'b0, 1'b0, 16'h0};
    chk("rst_async.ex_valid", ex_valid, 1'b0);
    chk_fields("rst_async");
    @(negedge clk);
    chk("rst_held.ex_valid", ex_valid, 1'b0);
    chk_fields("rst_held");
    reset = 1'b1;
    chk("rst_release.pending", dut.u_sb.pending_q, 64'h0);
    step("rst_after", 1'b1, 1'b0, 1'b1, 32'h9, 32'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
